wdm_peak_search: RTL and testbench
==================================

Name: wdm_peak_search

Overview:
- Closed-loop wavelength-search controller: the receive-to-transmit return path from the photodetector back to the tunable laser or ring wavelength.
- On start, steps a tuning code across its range and drives the matching real wavelength to the laser or ring model.
- At each step it waits for the optics to settle, then averages the photodetector current.
- Returns the code and wavelength of maximum received current, plus the peak value.
- Used in WDM laser-to-PD benches and as the basis for per-channel lock controllers.

Parameters:
- CodeWidth, 6, width of the tuning code; code range is 0..2**CodeWidth-1.
- StepSize, 1, code increment per sweep point; must be ≥1.
- SettleCycles, 4, cycles waited after each code change before sampling; must be ≥1.
- AvgCycles, 4, number of photodetector samples averaged per point; must be ≥1.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
- i_real_pd  input  real  photodetector current (from photodetector o_real_current)
- i_real_wvl_start  input  real  wavelength at code 0; sampled on accepted start
- i_real_wvl_step  input  real  wavelength per code LSB; sampled on accepted start
- i_real_thresh  input  real  minimum peak treated as a valid lock; sampled on accepted start
- o_code  output  CodeWidth  current tuning code; holds best code after DONE
- o_real_wvl  output  real  equals wvl_start + o_code*wvl_step, updated in the same cycle as o_code
- o_real_peak  output  real  best averaged current so far; final peak after DONE
- o_busy  output  1  high from the cycle after an accepted start until DONE completes
- o_done  output  1  one-cycle pulse when the result is valid
- o_found  output  1  valid with o_done and held until the next start; 1 iff final peak ≥ thresh

Behaviour:
- Reset values:
  - o_code=0, o_real_wvl=0.0, o_real_peak=0.0.
  - o_busy=0, o_done=0, o_found=0.
  - State IDLE; all counters and the accumulator cleared.
- States: IDLE, SETTLE, SAMPLE, COMPARE, DONE.
- IDLE:
  - i_start=1 latches start, step and thresh.
  - Next cycle: state SETTLE, o_code=0, o_real_wvl=wvl_start, o_busy=1, best_code=0, o_real_peak=-infinity sentinel (any real below all legal currents; the team uses -1.0e30).
- SETTLE: counts SettleCycles cycles, then moves to SAMPLE. i_real_pd is ignored while in SETTLE.
- SAMPLE:
  - Adds i_real_pd to the accumulator every cycle for AvgCycles cycles, then moves to COMPARE.
  - The accumulator is cleared on entry to SETTLE.
- COMPARE (one cycle):
  - avg = acc / AvgCycles.
  - If avg > o_real_peak (strictly greater), then o_real_peak=avg and best_code=o_code. Ties keep the earlier, lower code.
  - If o_code + StepSize > 2**CodeWidth-1: go to DONE. There is no wrap-around, so the last point is the largest reachable multiple of StepSize.
  - Otherwise o_code += StepSize and go to SETTLE.
- DONE (one cycle):
  - o_code=best_code and o_real_wvl is recomputed.
  - o_done=1 and o_found=(o_real_peak ≥ thresh).
  - Next cycle: IDLE, o_busy=0; o_code, o_real_wvl, o_real_peak and o_found are held.
- Latency per point: SettleCycles+AvgCycles+1 cycles.
- Total latency from the accepted start cycle to the o_done cycle: 1 + N*(SettleCycles+AvgCycles+1), where N = floor((2**CodeWidth-1)/StepSize)+1.
- i_start while o_busy=1, including the DONE cycle: ignored, no restart.
- Reset mid-sweep: immediate return to reset values on the next edge; no o_done pulse.
- Input changes: changes to i_real_wvl_* or i_real_thresh during a sweep have no effect.
- NaN on i_real_pd is not supported.

Decomposition:
- wdm_pkg adds:
  - typedef of the search state enum;
  - constant PD_PEAK_FLOOR = -1.0e30;
  - function code_to_wvl(start, step, code) returning real, shared with other tuner blocks.
- One sub-module, wdm_pd_averager, which owns the accumulator, the AvgCycles counter, and the valid/avg outputs.
- The top-level block holds the state machine, settle counter, code register and best-value tracking.

Test Plan:
- Reset check: hold i_rst 3 cycles mid-sweep (code=10) -> next cycle o_code=0, o_busy=0, o_done=0, state IDLE; a later start sweeps from 0.
- Single peak: PD model returns 1.0e-3 at code 37 and 1.0e-5 elsewhere, thresh 5.0e-4, wvl_start 1300.0, step 0.1 -> o_done after 1+64*9=577 cycles, o_code=37, o_real_wvl=1303.7, o_real_peak=1.0e-3, o_found=1.
- Tie and threshold: equal current 2.0e-4 at codes 12 and 40, thresh 5.0e-4 -> o_code=12, o_found=0.
- Step boundary: StepSize=5, CodeWidth=6 -> codes visited are 0,5,…,60 (13 points) and never 65; o_done at cycle 1+13*9=118.
- Averaging: AvgCycles=4, PD alternates 0.0/2.0 during SAMPLE at code 3 and holds a constant 0.9 elsewhere -> avg 1.0 at code 3, so o_code=3; checker confirms SETTLE-phase samples are excluded.
- Handshake: i_start pulsed at cycles 50 and 577 (the DONE cycle) of a sweep -> both ignored, exactly one o_done pulse; a start in the following IDLE cycle begins a new sweep with o_found cleared.

Source files
------------

// File: rtl/wdm_pkg.sv
// Shared types, constants and helpers for the WDM tuner blocks.
package wdm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_COMPARE,
        ST_DONE
    } search_state_e;

    // Below every legal photodetector current, so the first sweep point always wins.
    localparam real PD_PEAK_FLOOR = -1.0e30;

    function automatic real code_to_wvl(input real start, input real step, input int unsigned code);
        return start + real'(code) * step;
    endfunction

endpackage

// File: rtl/wdm_pd_averager.sv
// Accumulates AvgCycles photodetector samples and presents their mean.
module wdm_pd_averager #(
    parameter int AvgCycles = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    input  real  pd_i,
    output logic last_o,
    output logic valid_o,
    output real  avg_o
);

    localparam int CntW = $clog2(AvgCycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    real             acc_q, acc_d;

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = 0.0;
            cnt_d = '0;
        end else if (en_i && !valid_o) begin
            acc_d = acc_q + pd_i;
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= 0.0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign last_o  = en_i && (cnt_q == CntW'(AvgCycles - 1));
    assign valid_o = (cnt_q == CntW'(AvgCycles));
    assign avg_o   = acc_q / real'(AvgCycles);

endmodule

// File: rtl/wdm_peak_search.sv
// Sweeps the tuning code, averages the photodetector at each point and
// returns the code, wavelength and current of the strongest response.
module wdm_peak_search
    import wdm_pkg::*;
#(
    parameter int CodeWidth    = 6,
    parameter int StepSize     = 1,
    parameter int SettleCycles = 4,
    parameter int AvgCycles    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  real                  i_real_pd,
    input  real                  i_real_wvl_start,
    input  real                  i_real_wvl_step,
    input  real                  i_real_thresh,
    output logic [CodeWidth-1:0] o_code,
    output real                  o_real_wvl,
    output real                  o_real_peak,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_found
);

    localparam int MaxCode = 2**CodeWidth - 1;
    localparam int SetW    = $clog2(SettleCycles + 1);

    search_state_e        state_q, state_d;
    logic [SetW-1:0]      settle_q, settle_d;
    logic [CodeWidth-1:0] code_q, code_d;
    logic [CodeWidth-1:0] best_q, best_d;
    real                  peak_q, peak_d;
    real                  wvl_q, wvl_d;
    real                  start_q, start_d;
    real                  step_q, step_d;
    real                  thresh_q, thresh_d;
    logic                 found_q, found_d;

    logic avg_clr, avg_en, avg_last, avg_valid;
    real  avg_val;

    wdm_pd_averager #(
        .AvgCycles (AvgCycles)
    ) u_avg (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .clr_i   (avg_clr),
        .en_i    (avg_en),
        .pd_i    (i_real_pd),
        .last_o  (avg_last),
        .valid_o (avg_valid),
        .avg_o   (avg_val)
    );

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        code_d   = code_q;
        best_d   = best_q;
        peak_d   = peak_q;
        wvl_d    = wvl_q;
        start_d  = start_q;
        step_d   = step_q;
        thresh_d = thresh_q;
        found_d  = found_q;
        avg_clr  = 1'b0;
        avg_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    start_d  = i_real_wvl_start;
                    step_d   = i_real_wvl_step;
                    thresh_d = i_real_thresh;
                    code_d   = '0;
                    best_d   = '0;
                    peak_d   = PD_PEAK_FLOOR;
                    wvl_d    = i_real_wvl_start;
                    found_d  = 1'b0;
                    settle_d = '0;
                    avg_clr  = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SetW'(SettleCycles - 1)) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + SetW'(1);
                end
            end
            ST_SAMPLE: begin
                avg_en = 1'b1;
                if (avg_last) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                // Strictly greater: on a tie the earlier, lower code is kept.
                if (avg_valid && (avg_val > peak_q)) begin
                    peak_d = avg_val;
                    best_d = code_q;
                end
                if (int'(code_q) + StepSize > MaxCode) begin
                    code_d  = best_d;
                    wvl_d   = code_to_wvl(start_q, step_q, 32'(best_d));
                    found_d = (peak_d >= thresh_q);
                    state_d = ST_DONE;
                end else begin
                    code_d   = code_q + CodeWidth'(StepSize);
                    wvl_d    = code_to_wvl(start_q, step_q, 32'(code_d));
                    settle_d = '0;
                    avg_clr  = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            code_q   <= '0;
            best_q   <= '0;
            peak_q   <= 0.0;
            wvl_q    <= 0.0;
            start_q  <= 0.0;
            step_q   <= 0.0;
            thresh_q <= 0.0;
            found_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            code_q   <= code_d;
            best_q   <= best_d;
            peak_q   <= peak_d;
            wvl_q    <= wvl_d;
            start_q  <= start_d;
            step_q   <= step_d;
            thresh_q <= thresh_d;
            found_q  <= found_d;
        end
    end

    assign o_code      = code_q;
    assign o_real_wvl  = wvl_q;
    assign o_real_peak = peak_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
    assign o_found     = found_q;

endmodule

// File: tb/tb_wdm_peak_search.sv
// Scoreboard bench for wdm_peak_search: a step-1 instance and a step-5 instance.
module tb_wdm_peak_search;

    localparam int CW = 6;
    localparam int S  = 4;
    localparam int A  = 4;
    localparam int PT = S + A + 1;

    typedef struct {
        int  code;
        real wvl;
        real peak;
        int  found;
        int  done_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start, start5;
    real           pd, wvl_start, wvl_step, thresh;
    real           pd5, wvl_start5, wvl_step5, thresh5;
    logic [CW-1:0] code, code5;
    real           wvl, peak, wvl5, peak5;
    logic          busy, done, found, busy5, done5, found5;

    real  pd_tab [64];
    real  pd5_tab[64];
    bit   seen5  [64];
    exp_t sb[$];
    exp_t sb5[$];
    exp_t got_e, got_e5;

    int n_cmp    = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int mode     = 0;
    int ph       = 0;
    int last_code = 0;
    logic last_busy = 1'b0;

    wdm_peak_search #(.CodeWidth(CW), .StepSize(1), .SettleCycles(S), .AvgCycles(A)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_real_pd(pd),
        .i_real_wvl_start(wvl_start), .i_real_wvl_step(wvl_step), .i_real_thresh(thresh),
        .o_code(code), .o_real_wvl(wvl), .o_real_peak(peak),
        .o_busy(busy), .o_done(done), .o_found(found)
    );

    wdm_peak_search #(.CodeWidth(CW), .StepSize(5), .SettleCycles(S), .AvgCycles(A)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_start(start5), .i_real_pd(pd5),
        .i_real_wvl_start(wvl_start5), .i_real_wvl_step(wvl_step5), .i_real_thresh(thresh5),
        .o_code(code5), .o_real_wvl(wvl5), .o_real_peak(peak5),
        .o_busy(busy5), .o_done(done5), .o_found(found5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input real got, input real exp);
        real mag;
        real tol;
        mag = (exp < 0.0) ? -exp : exp;
        tol = 1.0e-9 * ((mag > 1.0) ? mag : 1.0);
        n_cmp++;
        if ((got - exp > tol) || (exp - got > tol)) begin
            n_bad++;
            $display("FAIL %s: got %g expected %g", tag, got, exp);
        end
    endtask

    // Photodetector model: phase counts cycles since the code last moved.
    always @(posedge clk) begin
        #1;
        if (busy && (!last_busy || int'(code) != last_code)) ph = 0;
        else ph++;
        last_busy = busy;
        last_code = int'(code);
        if (mode == 2 && code == 3)
            pd = (ph < S || ph >= S + A) ? 50.0 : ((((ph - S) % 2) == 1) ? 2.0 : 0.0);
        else
            pd = pd_tab[code];
        pd5 = pd5_tab[code5];
    end

    always @(negedge clk) begin
        if (busy5 && !done5) seen5[code5] = 1'b1;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                got_e = sb.pop_front();
                check("done_code",  code,  got_e.code);
                check("done_wvl",   wvl,   got_e.wvl);
                check("done_peak",  peak,  got_e.peak);
                check("done_found", found, got_e.found);
                check("done_cycle", cyc,   got_e.done_cyc);
                check("done_busy",  busy,  1);
            end
        end
        if (done5) begin
            if (sb5.size() == 0) begin
                check("unexpected_done5", 1, 0);
            end else begin
                got_e5 = sb5.pop_front();
                check("done5_code",  code5,  got_e5.code);
                check("done5_wvl",   wvl5,   got_e5.wvl);
                check("done5_peak",  peak5,  got_e5.peak);
                check("done5_found", found5, got_e5.found);
                check("done5_cycle", cyc,    got_e5.done_cyc);
            end
        end
    end

    function automatic real point_val(input int c);
        return (mode == 2 && c == 3) ? 1.0 : pd_tab[c];
    endfunction

    function automatic exp_t model(input int step, input bit five, input real ws, input real wst, input real th);
        exp_t e;
        real  best;
        real  v;
        int   bc;
        best = -1.0e30;
        bc   = 0;
        for (int c = 0; c < 64; c += step) begin
            v = five ? pd5_tab[c] : point_val(c);
            if (v > best) begin
                best = v;
                bc   = c;
            end
        end
        e.code     = bc;
        e.wvl      = ws + real'(bc) * wst;
        e.peak     = best;
        e.found    = (best >= th) ? 1 : 0;
        e.done_cyc = 0;
        return e;
    endfunction

    task automatic run_start(input real ws, input real wst, input real th, input bit already);
        exp_t e;
        wvl_start = ws;
        wvl_step  = wst;
        thresh    = th;
        e = model(1, 1'b0, ws, wst, th);
        if (!already) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        e.done_cyc = cyc + 64 * PT;
        sb.push_back(e);
    endtask

    task automatic wait_done(input bit which, input int budget);
        int n;
        n = 0;
        while (!(which ? done5 : done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(which ? done5 : done)) check(which ? "done5_timeout" : "done_timeout", 0, 1);
    endtask

    task automatic check_sweep_begin(input real ws);
        @(negedge clk);
        check("start_code", code, 0);
        check("start_busy", busy, 1);
        check("start_wvl",  wvl,  ws);
        check("start_peak", peak, -1.0e30);
    endtask

    initial begin
        exp_t e5;
        int   n;
        int   cnt;
        int   mx;

        rst = 1'b1; start = 1'b0; start5 = 1'b0;
        pd = 0.0; pd5 = 0.0;
        wvl_start = 0.0; wvl_step = 0.0; thresh = 0.0;
        wvl_start5 = 0.0; wvl_step5 = 0.0; thresh5 = 0.0;
        for (int i = 0; i < 64; i++) begin
            pd_tab[i]  = 1.0e-5;
            pd5_tab[i] = 1.0;
            seen5[i]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_code",  code,  0);
        check("rst_wvl",   wvl,   0.0);
        check("rst_peak",  peak,  0.0);
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_found", found, 0);
        check("rst_busy5", busy5, 0);
        rst = 1'b0;

        // Single peak at code 37.
        mode = 0;
        pd_tab[37] = 1.0e-3;
        run_start(1300.0, 0.1, 5.0e-4, 1'b0);
        check_sweep_begin(1300.0);
        wait_done(1'b0, 700);
        @(negedge clk);
        check("idle_busy",  busy,  0);
        check("idle_done",  done,  0);
        check("hold_code",  code,  37);
        check("hold_wvl",   wvl,   1303.7);
        check("hold_peak",  peak,  1.0e-3);
        check("hold_found", found, 1);

        // Starts at cycle 50 and in the DONE cycle are ignored; the next IDLE start is taken.
        run_start(1300.0, 0.1, 5.0e-4, 1'b0);
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, 700);
        start = 1'b1;
        @(negedge clk);
        check("hs_idle_busy",  busy,  0);
        check("hs_idle_found", found, 1);
        pd_tab[37] = 1.0e-5;
        pd_tab[12] = 2.0e-4;
        pd_tab[40] = 2.0e-4;
        run_start(1310.0, 0.2, 5.0e-4, 1'b1);
        @(negedge clk);
        check("hs_found_clr", found, 0);
        check("hs_busy",      busy,  1);
        check("hs_code",      code,  0);
        wait_done(1'b0, 700);
        @(negedge clk);
        check("hs_done_pulses", done_cnt, 3);

        // Averaging window excludes settle samples.
        mode = 2;
        for (int i = 0; i < 64; i++) pd_tab[i] = 0.9;
        run_start(1550.0, 0.8, 0.5, 1'b0);
        wait_done(1'b0, 700);
        @(negedge clk);

        // Reset mid-sweep at code 10, then a fresh random sweep.
        mode = 0;
        for (int i = 0; i < 64; i++) pd_tab[i] = real'($urandom_range(1000, 0)) * 1.0e-6;
        run_start(1500.0, 0.05, 5.0e-4, 1'b0);
        n = 0;
        while (code != 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_code10", code, 10);
        void'(sb.pop_front());
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_code", code, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_peak", peak, 0.0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_start(1500.0, 0.05, 5.0e-4, 1'b0);
        check_sweep_begin(1500.0);
        wait_done(1'b0, 700);
        @(negedge clk);

        // Step-5 instance: 13 points, 0..60.
        pd5_tab[25] = 3.0;
        pd5_tab[62] = 9.0;
        pd5_tab[63] = 9.0;
        for (int i = 0; i < 64; i++) seen5[i] = 1'b0;
        wvl_start5 = 1500.0;
        wvl_step5  = 0.4;
        thresh5    = 2.0;
        e5 = model(5, 1'b1, 1500.0, 0.4, 2.0);
        @(negedge clk);
        start5 = 1'b1;
        @(posedge clk);
        #1;
        start5 = 1'b0;
        e5.done_cyc = cyc + 13 * PT;
        sb5.push_back(e5);
        wait_done(1'b1, 200);
        @(negedge clk);
        cnt = 0;
        mx  = 0;
        for (int i = 0; i < 64; i++) begin
            if (seen5[i]) begin
                cnt++;
                mx = i;
            end
        end
        check("step5_points",  cnt, 13);
        check("step5_maxcode", mx,  60);
        check("step5_code",    code5, 25);

        check("sb_left",   sb.size() + sb5.size(), 0);
        check("done_total", done_cnt, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
